// File: rtl/ofdm_cp_remover.sv
// OFDM cyclic-prefix remover: drops leading preamble symbols, strips the CP
// from every remaining symbol and emits whole FFT frames, zero-padding a
// truncated last symbol.
//
// Ports:
//   clk, reset (async, active-high), clear (sync)
//   cfg_fft_len/cfg_cp_len/cfg_skip : packet config, latched per packet
//   i_t* : AXI-stream input (packet stream, i_tlast = end of packet)
//   o_t* : AXI-stream output (o_tlast = end of frame, o_teob = end of packet)
//   o_sym_idx   : data-symbol index of the current output sample
//   err_partial : pulse when a packet ends inside the skip or CP region
module ofdm_cp_remover #(
   parameter int FFT_SIZE = 4096,
   parameter int CP_SIZE  = 512,
   parameter int MAX_SKIP = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [15:0] cfg_fft_len,
   input  logic [15:0] cfg_cp_len,
   input  logic [3:0]  cfg_skip,
   input  logic [31:0] i_tdata,
   input  logic        i_tlast,
   input  logic        i_tvalid,
   output logic        i_tready,
   output logic [31:0] o_tdata,
   output logic        o_tlast,
   output logic        o_teob,
   output logic        o_tvalid,
   input  logic        o_tready,
   output logic [7:0]  o_sym_idx,
   output logic        err_partial
);

   typedef enum logic [2:0] {
      IDLE,
      SKIP,
      CP,
      BODY,
      PAD
   } state_t;

   localparam logic [15:0] FFT_MAX  = 16'(FFT_SIZE);
   localparam logic [15:0] CP_MAX   = 16'(CP_SIZE);
   localparam logic [3:0]  SKIP_MAX = 4'(MAX_SKIP);

   state_t      state, state_n;
   logic [15:0] fft_r, fft_n;
   logic [15:0] cp_r, cp_n;
   logic [3:0]  skip_r, skip_n;
   logic [15:0] sample_cnt, sample_n;
   logic [15:0] skip_cnt, skip_cnt_n;
   logic [15:0] pad_cnt, pad_n;
   logic [7:0]  sym_idx, sym_n;

   logic [31:0] tdata_n;
   logic        tlast_n;
   logic        teob_n;
   logic        tvalid_n;
   logic [7:0]  sidx_n;
   logic        err_n;

   logic        out_en;
   logic [15:0] fft_c;
   logic [15:0] cp_c;
   logic [3:0]  skip_c;
   logic [15:0] sym_last;
   logic [15:0] fft_last;
   logic [15:0] cp_last;

   assign out_en = !o_tvalid || o_tready;

   assign fft_c = (cfg_fft_len == 16'd0 || cfg_fft_len > FFT_MAX)
                ? FFT_MAX : cfg_fft_len;
   assign cp_c  = (cfg_cp_len > CP_MAX) ? CP_MAX : cfg_cp_len;
   assign skip_c = (int'(cfg_skip) > MAX_SKIP) ? SKIP_MAX : cfg_skip;

   assign sym_last = cp_r + fft_r - 16'd1;
   assign fft_last = fft_r - 16'd1;
   assign cp_last  = cp_r - 16'd1;

   always_comb begin
      state_n    = state;
      fft_n      = fft_r;
      cp_n       = cp_r;
      skip_n     = skip_r;
      sample_n   = sample_cnt;
      skip_cnt_n = skip_cnt;
      pad_n      = pad_cnt;
      sym_n      = sym_idx;
      tdata_n    = o_tdata;
      tlast_n    = o_tlast;
      teob_n     = o_teob;
      sidx_n     = o_sym_idx;
      tvalid_n   = o_tvalid;
      err_n      = 1'b0;
      i_tready   = 1'b0;

      // A taken beat empties the register unless reloaded below.
      if (out_en) begin
         tvalid_n = 1'b0;
      end

      unique case (state)
         IDLE: begin
            if (i_tvalid) begin
               fft_n      = fft_c;
               cp_n       = cp_c;
               skip_n     = skip_c;
               sym_n      = 8'd0;
               sample_n   = 16'd0;
               skip_cnt_n = 16'd0;
               pad_n      = 16'd0;
               if (skip_c != 4'd0) begin
                  state_n = SKIP;
               end else if (cp_c != 16'd0) begin
                  state_n = CP;
               end else begin
                  state_n = BODY;
               end
            end
         end

         SKIP: begin
            i_tready = 1'b1;
            if (i_tvalid) begin
               if (i_tlast) begin
                  err_n      = 1'b1;
                  sample_n   = 16'd0;
                  skip_cnt_n = 16'd0;
                  state_n    = IDLE;
               end else if (sample_cnt == sym_last) begin
                  sample_n = 16'd0;
                  if (skip_cnt + 16'd1 == {12'd0, skip_r}) begin
                     skip_cnt_n = 16'd0;
                     state_n    = (cp_r != 16'd0) ? CP : BODY;
                  end else begin
                     skip_cnt_n = skip_cnt + 16'd1;
                  end
               end else begin
                  sample_n = sample_cnt + 16'd1;
               end
            end
         end

         CP: begin
            i_tready = 1'b1;
            if (i_tvalid) begin
               if (i_tlast) begin
                  err_n    = 1'b1;
                  sample_n = 16'd0;
                  state_n  = IDLE;
               end else if (sample_cnt == cp_last) begin
                  sample_n = 16'd0;
                  state_n  = BODY;
               end else begin
                  sample_n = sample_cnt + 16'd1;
               end
            end
         end

         BODY: begin
            i_tready = out_en;
            if (i_tvalid && out_en) begin
               tvalid_n = 1'b1;
               tdata_n  = i_tdata;
               sidx_n   = sym_idx;
               tlast_n  = 1'b0;
               teob_n   = 1'b0;
               if (sample_cnt == fft_last) begin
                  tlast_n  = 1'b1;
                  sample_n = 16'd0;
                  if (i_tlast) begin
                     teob_n  = 1'b1;
                     state_n = IDLE;
                  end else begin
                     if (sym_idx != 8'hff) begin
                        sym_n = sym_idx + 8'd1;
                     end
                     state_n = (cp_r != 16'd0) ? CP : BODY;
                  end
               end else if (i_tlast) begin
                  // Remaining samples of this frame become zeros.
                  pad_n    = fft_last - sample_cnt;
                  sample_n = 16'd0;
                  state_n  = PAD;
               end else begin
                  sample_n = sample_cnt + 16'd1;
               end
            end
         end

         PAD: begin
            if (out_en) begin
               tvalid_n = 1'b1;
               tdata_n  = 32'd0;
               sidx_n   = sym_idx;
               tlast_n  = (pad_cnt == 16'd1);
               teob_n   = (pad_cnt == 16'd1);
               pad_n    = pad_cnt - 16'd1;
               if (pad_cnt == 16'd1) begin
                  state_n = IDLE;
               end
            end
         end

         default: state_n = IDLE;
      endcase

      if (clear) begin
         state_n    = IDLE;
         fft_n      = 16'd0;
         cp_n       = 16'd0;
         skip_n     = 4'd0;
         sample_n   = 16'd0;
         skip_cnt_n = 16'd0;
         pad_n      = 16'd0;
         sym_n      = 8'd0;
         tdata_n    = 32'd0;
         tlast_n    = 1'b0;
         teob_n     = 1'b0;
         sidx_n     = 8'd0;
         tvalid_n   = 1'b0;
         err_n      = 1'b0;
         i_tready   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         fft_r       <= 16'd0;
         cp_r        <= 16'd0;
         skip_r      <= 4'd0;
         sample_cnt  <= 16'd0;
         skip_cnt    <= 16'd0;
         pad_cnt     <= 16'd0;
         sym_idx     <= 8'd0;
         o_tdata     <= 32'd0;
         o_tlast     <= 1'b0;
         o_teob      <= 1'b0;
         o_sym_idx   <= 8'd0;
         o_tvalid    <= 1'b0;
         err_partial <= 1'b0;
      end else begin
         state       <= state_n;
         fft_r       <= fft_n;
         cp_r        <= cp_n;
         skip_r      <= skip_n;
         sample_cnt  <= sample_n;
         skip_cnt    <= skip_cnt_n;
         pad_cnt     <= pad_n;
         sym_idx     <= sym_n;
         o_tdata     <= tdata_n;
         o_tlast     <= tlast_n;
         o_teob      <= teob_n;
         o_sym_idx   <= sidx_n;
         o_tvalid    <= tvalid_n;
         err_partial <= err_n;
      end
   end

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Bench for ofdm_cp_remover: directed and random packets against a
// position-arithmetic model of which samples survive.
module tb_ofdm_cp_remover;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic [15:0] cfg_fft_len = '0;
   logic [15:0] cfg_cp_len = '0;
   logic [3:0]  cfg_skip = '0;
   logic [31:0] i_tdata = '0;
   logic        i_tlast = 1'b0;
   logic        i_tvalid = 1'b0;
   logic        i_tready;
   logic [31:0] o_tdata;
   logic        o_tlast;
   logic        o_teob;
   logic        o_tvalid;
   logic        o_tready = 1'b1;
   logic [7:0]  o_sym_idx;
   logic        err_partial;

   ofdm_cp_remover dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .cfg_fft_len (cfg_fft_len),
      .cfg_cp_len  (cfg_cp_len),
      .cfg_skip    (cfg_skip),
      .i_tdata     (i_tdata),
      .i_tlast     (i_tlast),
      .i_tvalid    (i_tvalid),
      .i_tready    (i_tready),
      .o_tdata     (o_tdata),
      .o_tlast     (o_tlast),
      .o_teob      (o_teob),
      .o_tvalid    (o_tvalid),
      .o_tready    (o_tready),
      .o_sym_idx   (o_sym_idx),
      .err_partial (err_partial)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
      logic        e;
      logic [7:0]  x;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] pkt[$];
   bit          disc[$];
   int          err_exp;
   int          err_seen;
   int          checks = 0;
   int          failures = 0;
   int          bp_mode = 0;
   int          cyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output-ready pattern generator.
   always @(posedge clk) begin
      logic [3:0] pat;
      pat = 4'b1001;
      #1;
      case (bp_mode)
         1: o_tready = pat[cyc % 4];
         2: o_tready = 1'($urandom_range(0, 1));
         default: o_tready = 1'b1;
      endcase
      cyc++;
   end

   // Monitor: outputs are sampled on the falling edge, the beat is taken
   // on the following rising edge.
   exp_t        e;
   bit          stall_q = 0;
   logic [42:0] snap;
   always @(negedge clk) begin
      if (reset) begin
         stall_q = 0;
      end else begin
         if (err_partial) err_seen++;
         if (stall_q)
            chk("stable", 64'({o_tvalid, o_tlast, o_teob, o_sym_idx, o_tdata}),
                64'(snap));
         if (o_tvalid && o_tready) begin
            chk("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("out", 64'({o_tdata, o_tlast, o_teob, o_sym_idx}),
                   64'({e.d, e.l, e.e, e.x}));
            end
         end
         stall_q = o_tvalid && !o_tready;
         snap = {o_tvalid, o_tlast, o_teob, o_sym_idx, o_tdata};
      end
   end

   task automatic make_pkt(input int n, input bit ramp);
      pkt.delete();
      for (int i = 0; i < n; i++)
         pkt.push_back(ramp ? 32'(i) : $urandom);
   endtask

   // Reference: classify each packet position by arithmetic on the
   // symbol layout [skip symbols][cp|fft][cp|fft]...
   task automatic model(input int fl, input int cl, input int sk);
      int f, c, sl, pre, n, p, s, off, j;
      exp_t x;
      f = (fl == 0 || fl > 4096) ? 4096 : fl;
      c = (cl > 512) ? 512 : cl;
      sl = f + c;
      pre = sk * sl;
      n = pkt.size();
      disc.delete();
      err_exp = 0;
      for (int i = 0; i < n; i++) begin
         p = i - pre;
         s = (p < 0) ? 0 : p / sl;
         off = (p < 0) ? 0 : p % sl;
         if (p < 0 || off < c) begin
            disc.push_back(1);
            if (i == n - 1) err_exp++;
         end else begin
            disc.push_back(0);
            j = off - c;
            x.d = pkt[i];
            x.l = (j == f - 1);
            x.e = (i == n - 1) && (j == f - 1);
            x.x = 8'((s > 255) ? 255 : s);
            exp_q.push_back(x);
            if (i == n - 1) begin
               for (int z = j + 1; z < f; z++) begin
                  x.d = 32'd0;
                  x.l = (z == f - 1);
                  x.e = (z == f - 1);
                  exp_q.push_back(x);
               end
            end
         end
      end
   endtask

   // Presents samples [0, upto); cfg is scrambled after the first
   // handshake since the DUT must hold its latched copy.
   task automatic send(input int upto);
      int w;
      bit hs;
      for (int i = 0; i < upto; i++) begin
         i_tdata = pkt[i];
         i_tlast = (i == pkt.size() - 1);
         i_tvalid = 1'b1;
         w = 0;
         hs = 0;
         while (!hs && w < 64) begin
            @(negedge clk);
            if (w == 0 && i == 0)
               chk("idle_bubble", 64'(i_tready), 64'd0);
            if (w == 0 && i > 0 && disc[i])
               chk("drain_ready", 64'(i_tready), 64'd1);
            hs = i_tready;
            @(posedge clk);
            #1;
            w++;
         end
         if (!hs) chk("in_timeout", 64'(hs), 64'd1);
         if (i == 0) begin
            cfg_fft_len = 16'($urandom);
            cfg_cp_len = 16'($urandom);
            cfg_skip = 4'($urandom);
         end
      end
      i_tvalid = 1'b0;
      i_tlast = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 20000) begin
         @(negedge clk);
         chk("no_accept_after_last", 64'(i_tready), 64'd0);
         @(posedge clk);
         #1;
         w++;
      end
      chk("drain_done", 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic run(input int n, input int fl, input int cl,
                      input int sk, input bit ramp);
      make_pkt(n, ramp);
      cfg_fft_len = 16'(fl);
      cfg_cp_len = 16'(cl);
      cfg_skip = 4'(sk);
      model(fl, cl, sk);
      err_seen = 0;
      send(n);
      drain();
      chk("err_partial_count", 64'(err_seen), 64'(err_exp));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs",
          64'({o_tvalid, o_tlast, o_teob, o_tdata, o_sym_idx,
               err_partial, i_tready}), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Nominal, truncation in BODY, truncation in CP.
      run(40, 8, 2, 1, 1);
      run(35, 8, 2, 1, 1);
      run(31, 8, 2, 1, 1);
      run(40, 8, 2, 1, 0);

      // Backpressure 1,0,0,1.
      bp_mode = 1;
      run(40, 8, 2, 1, 0);
      run(35, 8, 2, 1, 0);
      bp_mode = 0;

      // Reset during sample 15.
      make_pkt(40, 1);
      cfg_fft_len = 16'd8;
      cfg_cp_len = 16'd2;
      cfg_skip = 4'd1;
      model(8, 2, 1);
      send(15);
      i_tdata = pkt[15];
      i_tvalid = 1'b1;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_tvalid", 64'(o_tvalid), 64'd0);
      i_tvalid = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      run(40, 8, 2, 1, 0);

      // Clear during sample 15.
      make_pkt(40, 1);
      cfg_fft_len = 16'd8;
      cfg_cp_len = 16'd2;
      cfg_skip = 4'd1;
      model(8, 2, 1);
      send(15);
      i_tdata = pkt[15];
      i_tvalid = 1'b1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      i_tvalid = 1'b0;
      chk("clear_tvalid", 64'(o_tvalid), 64'd0);
      chk("clear_tready", 64'(i_tready), 64'd0);
      exp_q.delete();
      run(40, 8, 2, 1, 0);

      // Edge configs.
      run(8192, 0, 0, 0, 0);
      run(520, 3, 600, 0, 0);
      run(50, 5000, 0, 0, 0);
      run(51, 2, 1, 15, 0);
      run(7, 1, 0, 0, 0);

      // Random packets under random backpressure.
      bp_mode = 2;
      for (int k = 0; k < 8; k++)
         run($urandom_range(1, 70), $urandom_range(1, 12),
             $urandom_range(0, 4), $urandom_range(0, 3), 0);
      bp_mode = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
